imem_loader: RTL and testbench

- Write-side counterpart of the CPU's instruction fetch path. The CPU only reads instruction memory (addr/rd_en/instr); this block fills that memory.
- Accepts a byte stream over a valid/ready handshake. Assembles big-endian 16-bit instruction words and writes them sequentially into instruction memory from address 0.
- Holds the CPU in reset until a complete image is loaded, then releases it.
- Sits between an external host link (UART or test harness) and the IM write port, alongside the CPU top.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/byte_pack16.sv | 35 +++
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, word width, default sizing.
package imem_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 65536;

    typedef enum logic [3:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DAT_HI,
        DAT_LO,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/byte_pack16.sv
// Two-beat big-endian byte-to-word assembler; word_vld_c flags the beat that completes a word.
module byte_pack16
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              beat,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_vld_c
);

    logic       phase;
    logic [7:0] hi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            hi_q  <= 8'd0;
        end else if (clr) begin
            phase <= 1'b0;
        end else if (beat) begin
            if (!phase) begin
                hi_q <= byte_in;
            end
            phase <= ~phase;
        end
    end

    // Low byte is taken straight from the bus so the word is usable on the completing edge.
    assign word_c     = {hi_q, byte_in};
    assign word_vld_c = beat & phase;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian word image into instruction memory and holds the CPU in reset until done.
// Optional trailing XOR checksum byte when LOADER_CKSUM_EN is defined.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_vld,
    output logic              byte_rdy,
    output logic [ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0] im_wdata,
    output logic              im_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    state_t            state;
    logic [WORD_W-1:0] cnt;
    logic              take;
    logic              beat;
    logic              restart;
    logic [WORD_W-1:0] word_c;
    logic              word_vld_c;

    assign take    = byte_vld & byte_rdy;
    assign beat    = take & (state != CHK);
    assign restart = start & (state inside {IDLE, DONE, ERR});

    byte_pack16 u_pack (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart),
        .beat       (beat),
        .byte_in    (byte_in),
        .word_c     (word_c),
        .word_vld_c (word_vld_c)
    );

`ifdef LOADER_CKSUM_EN
    logic [7:0] cks;

    // Running XOR over every count and data byte of the current load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cks <= 8'd0;
        end else if (restart) begin
            cks <= 8'd0;
        end else if (beat) begin
            cks <= cks ^ byte_in;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            byte_rdy  <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            im_we     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            im_we     <= 1'b0;
            cpu_rst_n <= done & ~err;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= CNT_HI;
                        byte_rdy  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cpu_rst_n <= 1'b0;
                        im_addr   <= '0;
                    end
                end
                CNT_HI: begin
                    if (take) state <= CNT_LO;
                end
                CNT_LO: begin
                    if (word_vld_c) begin
                        cnt <= word_c;
                        if (word_c == '0) begin
                            state    <= DONE;
                            byte_rdy <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (32'(word_c) > DEPTH) begin
                            state    <= ERR;
                            byte_rdy <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= DAT_HI;
                        end
                    end
                end
                DAT_HI: begin
                    if (take) state <= DAT_LO;
                end
                DAT_LO: begin
                    if (word_vld_c) begin
                        state    <= WRITE;
                        byte_rdy <= 1'b0;
                        im_we    <= 1'b1;
                        im_wdata <= word_c;
                    end
                end
                WRITE: begin
                    im_addr <= im_addr + ADDR_W'(1);
                    cnt     <= cnt - WORD_W'(1);
                    if (cnt == WORD_W'(1)) begin
`ifdef LOADER_CKSUM_EN
                        state    <= CHK;
                        byte_rdy <= 1'b1;
`else
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
`endif
                    end else begin
                        state    <= DAT_HI;
                        byte_rdy <= 1'b1;
                    end
                end
                CHK: begin
`ifdef LOADER_CKSUM_EN
                    if (take) begin
                        byte_rdy <= 1'b0;
                        busy     <= 1'b0;
                        if (byte_in == cks) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
`else
                    state    <= IDLE;
                    byte_rdy <= 1'b0;
`endif
                end
                default: begin
                    state    <= IDLE;
                    byte_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed byte streams, expected IM writes queued and checked by a monitor.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_vld;
    logic        byte_rdy;
    logic [15:0] im_addr;
    logic [15:0] im_wdata;
    logic        im_we;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst_n;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb[$];
    logic [15:0] dat[8];

    imem_loader #(.ADDR_W(16), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byte_in   (byte_in),
        .byte_vld  (byte_vld),
        .byte_rdy  (byte_rdy),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .im_we     (im_we),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_rst_n (cpu_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every IM write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && im_we) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL im_write: got addr=%0h data=%0h expected no write", im_addr, im_wdata);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if ({im_addr, im_wdata} !== e) begin
                    bad++;
                    $display("FAIL im_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             im_addr, im_wdata, e[31:16], e[15:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_rdy", 32'(byte_rdy), 32'd1);
        check("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_rdy);
        bit ok;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            byte_vld = 1'b0;
            if (chk_rdy) check("rdy_in_gap", 32'(byte_rdy), 32'd1);
            @(posedge clk); #1;
        end
        byte_in  = b;
        byte_vld = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (byte_rdy) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        byte_vld = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL byte_timeout: got byte_rdy=0 expected 1 for byte %0h", b);
        end
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done || err) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL end_timeout: got done=%0d err=%0d expected one of them set", done, err);
        end
    endtask

    // Full load: count, nw words from dat[], then checksum when the build expects one.
    task automatic load(input logic [15:0] n, input int nw, input int gap);
        logic [7:0] x;
        x = 8'd0;
        pulse_start();
        send_byte(n[15:8], gap, gap > 0);
        send_byte(n[7:0], gap, gap > 0);
        x = n[15:8] ^ n[7:0];
        for (int i = 0; i < nw; i++) begin
            sb.push_back({16'(i), dat[i]});
            send_byte(dat[i][15:8], gap, (gap > 0) && (i == 0));
            send_byte(dat[i][7:0], gap, gap > 0);
            x = x ^ dat[i][15:8] ^ dat[i][7:0];
        end
`ifdef LOADER_CKSUM_EN
        if (nw > 0 && 16'(nw) == n) send_byte(x, 0, 1'b0);
`endif
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        byte_in  = 8'd0;
        byte_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_rdy", 32'(byte_rdy), 32'd0);
        check("rst_im_we", 32'(im_we), 32'd0);
        check("rst_im_addr", 32'(im_addr), 32'd0);
        check("rst_im_wdata", 32'(im_wdata), 32'd0);
        check("rst_flags", {29'd0, busy, done, err}, 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_rdy", 32'(byte_rdy), 32'd0);

        // Two-word image
        dat[0] = 16'h1234;
        dat[1] = 16'hABCD;
        load(16'd2, 2, 0);
        wait_end();
        check("w2_done_err", {30'd0, done, err}, 32'b10);
        check("w2_busy", 32'(busy), 32'd0);
        check("w2_rdy", 32'(byte_rdy), 32'd0);
        check("w2_cpu_first", 32'(cpu_rst_n), 32'd0);
        check("w2_addr", 32'(im_addr), 32'd2);
        @(posedge clk); #1;
        check("w2_cpu_next", 32'(cpu_rst_n), 32'd1);
        check("w2_sb_empty", 32'(sb.size()), 32'd0);

        // Empty image
        load(16'd0, 0, 0);
        wait_end();
        check("n0_done_err", {30'd0, done, err}, 32'b10);
        check("n0_addr", 32'(im_addr), 32'd0);
        @(posedge clk); #1;
        check("n0_cpu", 32'(cpu_rst_n), 32'd1);

        // Count above DEPTH
        load(16'd5, 0, 0);
        wait_end();
        check("big_done_err", {30'd0, done, err}, 32'b01);
        check("big_rdy", 32'(byte_rdy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("big_cpu", 32'(cpu_rst_n), 32'd0);
        check("big_err_sticky", 32'(err), 32'd1);

        // Single word with stalls between bytes
        dat[0] = 16'h7E11;
        load(16'd1, 1, 5);
        wait_end();
        check("gap_done_err", {30'd0, done, err}, 32'b10);
        check("gap_addr", 32'(im_addr), 32'd1);

        // Count exactly DEPTH
        dat[0] = 16'h0001;
        dat[1] = 16'h0203;
        dat[2] = 16'hFFFF;
        dat[3] = 16'h8000;
        load(16'd4, 4, 0);
        wait_end();
        check("full_done_err", {30'd0, done, err}, 32'b10);
        check("full_addr", 32'(im_addr), 32'd4);
        check("full_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while the third word's low byte is pending
        pulse_start();
        sb.push_back({16'd0, 16'hA1A2});
        sb.push_back({16'd1, 16'hB1B2});
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h04, 0, 1'b0);
        send_byte(8'hA1, 0, 1'b0);
        send_byte(8'hA2, 0, 1'b0);
        send_byte(8'hB1, 0, 1'b0);
        send_byte(8'hB2, 0, 1'b0);
        send_byte(8'hC1, 0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_rdy_we", {30'd0, byte_rdy, im_we}, 32'd0);
        check("mid_rst_addr", 32'(im_addr), 32'd0);
        check("mid_rst_wdata", 32'(im_wdata), 32'd0);
        check("mid_rst_flags", {28'd0, busy, done, err, cpu_rst_n}, 32'd0);
        check("mid_rst_sb", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        dat[0] = 16'h55AA;
        load(16'd1, 1, 0);
        wait_end();
        check("reload_done_err", {30'd0, done, err}, 32'b10);
        check("reload_addr", 32'(im_addr), 32'd1);

`ifdef LOADER_CKSUM_EN
        pulse_start();
        sb.push_back({16'd0, 16'h1234});
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        send_byte(8'h27, 0, 1'b0);
        wait_end();
        check("cks_ok_done_err", {30'd0, done, err}, 32'b10);

        pulse_start();
        sb.push_back({16'd0, 16'h1234});
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        send_byte(8'h26, 0, 1'b0);
        wait_end();
        check("cks_bad_done_err", {30'd0, done, err}, 32'b01);
        @(posedge clk); #1;
        check("cks_bad_cpu", 32'(cpu_rst_n), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
